// File: rtl/stream_width_packer.sv
// stream_width_packer: packs RATIO narrow IN_WIDTH beats into one wide word.
// A beat with in_last, or the beat that fills the last lane, closes the word;
// a closed word is presented one cycle later with its lane count and last flag.
// Build option: define STREAM_PACKER_MSB_FIRST_EN to put the first beat in the
// most significant lane instead of the least significant one.
module stream_width_packer #(
    parameter int IN_WIDTH = 4,
    parameter int RATIO    = 4,
    parameter int CNT_W    = $clog2(RATIO + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [IN_WIDTH-1:0]          in_data,
    input  logic                         in_valid,
    input  logic                         in_last,
    output logic                         in_ready,
    output logic [IN_WIDTH*RATIO-1:0]    out_data,
    output logic                         out_valid,
    output logic                         out_last,
    output logic [CNT_W-1:0]             out_count,
    input  logic                         out_ready
);

    localparam int OUT_W  = IN_WIDTH * RATIO;
    localparam int ACC_W  = IN_WIDTH * (RATIO - 1);
    localparam int LIDX_W = $clog2(RATIO);

    logic [ACC_W-1:0]    acc;
    logic [LIDX_W-1:0]   lane_idx;
    logic [OUT_W-1:0]    packed_word;
    logic [OUT_W-1:0]    acc_ext;
    logic [IN_WIDTH-1:0] lane_val;
    logic                in_fire;
    logic                completing;

    // The output register frees up in the same cycle the sink takes it.
    assign in_ready   = !out_valid || out_ready;
    assign in_fire    = in_valid && in_ready;
    assign completing = (lane_idx == LIDX_W'(RATIO - 1)) || in_last;

    // Assemble the word that a completing beat would produce. Accumulator lanes
    // at or above lane_idx are always zero, so unused lanes come out as zero.
    always_comb begin
        packed_word = '0;
        lane_val    = '0;
        acc_ext     = {{IN_WIDTH{1'b0}}, acc};
        for (int k = 0; k < RATIO; k++) begin
            if (lane_idx == LIDX_W'(k)) begin
                lane_val = in_data;
            end else begin
                lane_val = acc_ext[k*IN_WIDTH +: IN_WIDTH];
            end
`ifdef STREAM_PACKER_MSB_FIRST_EN
            packed_word[(RATIO-1-k)*IN_WIDTH +: IN_WIDTH] = lane_val;
`else
            packed_word[k*IN_WIDTH +: IN_WIDTH] = lane_val;
`endif
        end
    end

    // Accumulate non-completing beats; a completing beat clears the partial word.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            lane_idx <= '0;
        end else if (in_fire) begin
            if (completing) begin
                acc      <= '0;
                lane_idx <= '0;
            end else begin
                for (int k = 0; k < RATIO - 1; k++) begin
                    if (lane_idx == LIDX_W'(k)) begin
                        acc[k*IN_WIDTH +: IN_WIDTH] <= in_data;
                    end
                end
                lane_idx <= lane_idx + LIDX_W'(1);
            end
        end
    end

    // Output register: load on a completing beat, otherwise drop valid once taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_count <= '0;
        end else if (in_fire && completing) begin
            out_valid <= 1'b1;
            out_data  <= packed_word;
            out_last  <= in_last;
            out_count <= CNT_W'(lane_idx) + CNT_W'(1);
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
